// File: rtl/csr_file.sv
// Machine-mode CSR file with trap entry / MRET sequencing for a single-hart pipeline.
// Decode reads combinationally; writeback writes, traps and returns are taken on the clock edge.
module csr_file (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_V,
    input  logic        WB_ST_CSR,
    input  logic [63:0] WB_CSR_DATA,
    input  logic [31:0] WB_IR,
    input  logic        WB_CS,
    input  logic [63:0] WB_CAUSE,
    input  logic [63:0] WB_EPC,
    input  logic        WB_MRET,
    input  logic        TIMER,
    input  logic        EXTERNAL,
    input  logic [11:0] DE_CSR_ADDR,
    output logic [63:0] CSR_RDATA,
    output logic        CSR_PC_MUX,
    output logic [63:0] CSR_TRAP_PC,
    output logic        CSR_STALL,
    output logic        CSR_INT_PENDING,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SAVE     = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    logic [1:0]  state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic [63:0] target_q, target_d;

    logic [11:0] wb_addr;
    logic        csr_we;
    logic [63:0] trap_base;
    logic [63:0] trap_vector;
    logic [63:0] mstatus_rd;
    logic [63:0] mie_rd;
    logic [63:0] mip_rd;
    logic        unused_ir_low;

    assign wb_addr       = WB_IR[31:20];
    assign unused_ir_low = ^WB_IR[19:0];

    // Only a write in IDLE with no concurrent trap or return is committed.
    assign csr_we = WB_V & WB_ST_CSR & (state_q == ST_IDLE) & ~WB_CS & ~WB_MRET;

    assign trap_base   = {mtvec_q[63:2], 2'b00};
    assign trap_vector = (mtvec_q[0] & WB_CAUSE[63])
                       ? trap_base + {56'd0, WB_CAUSE[5:0], 2'b00}
                       : trap_base;

    always_comb begin
        mstatus_rd     = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]  = mstatus_mpie_q;
        mstatus_rd[3]  = mstatus_mie_q;
        mie_rd         = '0;
        mie_rd[7]      = mie_mtie_q;
        mie_rd[11]     = mie_meie_q;
        mip_rd         = '0;
        mip_rd[7]      = TIMER;
        mip_rd[11]     = EXTERNAL;
    end

    always_comb begin
        CSR_RDATA = '0;
        case (DE_CSR_ADDR)
            A_MSTATUS:  CSR_RDATA = mstatus_rd;
            A_MIE:      CSR_RDATA = mie_rd;
            A_MTVEC:    CSR_RDATA = mtvec_q;
            A_MSCRATCH: CSR_RDATA = mscratch_q;
            A_MEPC:     CSR_RDATA = mepc_q;
            A_MCAUSE:   CSR_RDATA = mcause_q;
            A_MIP:      CSR_RDATA = mip_rd;
            A_MCYCLE:   CSR_RDATA = mcycle_q;
            A_MINSTRET: CSR_RDATA = minstret_q;
            default:    CSR_RDATA = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        target_d       = target_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = (WB_V & ~WB_CS) ? minstret_q + 64'd1 : minstret_q;

        case (state_q)
            ST_IDLE: begin
                if (WB_CS) begin
                    mepc_d         = {WB_EPC[63:2], 2'b00};
                    mcause_d       = WB_CAUSE;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    target_d       = trap_vector;
                    state_d        = ST_SAVE;
                end else if (WB_MRET) begin
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                    target_d       = mepc_q;
                    state_d        = ST_REDIRECT;
                end else if (csr_we) begin
                    // Counter writes override the increment computed above.
                    case (wb_addr)
                        A_MSTATUS: begin
                            mstatus_mie_d  = WB_CSR_DATA[3];
                            mstatus_mpie_d = WB_CSR_DATA[7];
                        end
                        A_MIE: begin
                            mie_mtie_d = WB_CSR_DATA[7];
                            mie_meie_d = WB_CSR_DATA[11];
                        end
                        A_MTVEC:    mtvec_d    = {WB_CSR_DATA[63:2], 1'b0, WB_CSR_DATA[0]};
                        A_MSCRATCH: mscratch_d = WB_CSR_DATA;
                        A_MEPC:     mepc_d     = {WB_CSR_DATA[63:2], 2'b00};
                        A_MCAUSE:   mcause_d   = WB_CSR_DATA;
                        A_MCYCLE:   mcycle_d   = WB_CSR_DATA;
                        A_MINSTRET: minstret_d = WB_CSR_DATA;
                        default: ;
                    endcase
                end
            end
            ST_SAVE:     state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= ST_IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            target_q       <= '0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            target_q       <= target_d;
        end
    end

    assign CSR_STALL       = (state_q != ST_IDLE);
    assign CSR_PC_MUX      = (state_q == ST_REDIRECT);
    assign CSR_TRAP_PC     = target_q;
    assign CSR_INT_PENDING = mstatus_mie_q & |(mie_rd & mip_rd);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: CSR field masking, counters, trap entry, MRET and reset abort.
module tb_csr_file;
    logic        CLK;
    logic        RESET;
    logic        WB_V;
    logic        WB_ST_CSR;
    logic [63:0] WB_CSR_DATA;
    logic [31:0] WB_IR;
    logic        WB_CS;
    logic [63:0] WB_CAUSE;
    logic [63:0] WB_EPC;
    logic        WB_MRET;
    logic        TIMER;
    logic        EXTERNAL;
    logic [11:0] DE_CSR_ADDR;
    logic [63:0] CSR_RDATA;
    logic        CSR_PC_MUX;
    logic [63:0] CSR_TRAP_PC;
    logic        CSR_STALL;
    logic        CSR_INT_PENDING;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    csr_file dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_ST_CSR(WB_ST_CSR),
        .WB_CSR_DATA(WB_CSR_DATA), .WB_IR(WB_IR), .WB_CS(WB_CS),
        .WB_CAUSE(WB_CAUSE), .WB_EPC(WB_EPC), .WB_MRET(WB_MRET),
        .TIMER(TIMER), .EXTERNAL(EXTERNAL), .DE_CSR_ADDR(DE_CSR_ADDR),
        .CSR_RDATA(CSR_RDATA), .CSR_PC_MUX(CSR_PC_MUX), .CSR_TRAP_PC(CSR_TRAP_PC),
        .CSR_STALL(CSR_STALL), .CSR_INT_PENDING(CSR_INT_PENDING), .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        DE_CSR_ADDR = addr;
        #1;
        check(tag, CSR_RDATA, exp);
    endtask

    task automatic wb_write(input logic [11:0] addr, input logic [63:0] data);
        WB_V        = 1'b1;
        WB_ST_CSR   = 1'b1;
        WB_IR       = {addr, 20'h00073};
        WB_CSR_DATA = data;
        tick();
        WB_V      = 1'b0;
        WB_ST_CSR = 1'b0;
    endtask

    task automatic wb_trap(input logic [63:0] cause, input logic [63:0] epc);
        WB_V     = 1'b1;
        WB_CS    = 1'b1;
        WB_CAUSE = cause;
        WB_EPC   = epc;
        tick();
        WB_V  = 1'b0;
        WB_CS = 1'b0;
    endtask

    initial begin
        int stall_cnt;
        int pcmux_cnt;
        logic [63:0] redirect_pc;

        RESET = 1'b0; WB_V = 1'b0; WB_ST_CSR = 1'b0; WB_CSR_DATA = '0; WB_IR = '0;
        WB_CS = 1'b0; WB_CAUSE = '0; WB_EPC = '0; WB_MRET = 1'b0;
        TIMER = 1'b0; EXTERNAL = 1'b0; DE_CSR_ADDR = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_stall", {63'd0, CSR_STALL}, 64'd0);
        check("rst_pcmux", {63'd0, CSR_PC_MUX}, 64'd0);
        check("rst_trap_pc", CSR_TRAP_PC, 64'd0);
        check_csr("rst_mstatus", 12'h300, 64'h1800);
        check_csr("rst_mcycle", 12'hB00, 64'd0);
        check_csr("rst_unimpl", 12'h123, 64'd0);
        RESET = 1'b1;
        tick();

        // mip follows the raw lines combinationally
        TIMER = 1'b1;
        check_csr("mip_timer", 12'h344, 64'h80);
        EXTERNAL = 1'b1;
        check_csr("mip_both", 12'h344, 64'h880);
        wb_write(12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
        TIMER = 1'b0; EXTERNAL = 1'b0;
        check_csr("mip_ro", 12'h344, 64'h0);

        // Field masks
        wb_write(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
        check_csr("mie_mask", 12'h304, 64'h880);
        wb_write(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        check_csr("mstatus_mask", 12'h300, 64'h1888);
        wb_write(12'h305, 64'h3);
        check_csr("mtvec_mode3", 12'h305, 64'h1);
        wb_write(12'h305, 64'h8000_0002);
        check_csr("mtvec_mode2", 12'h305, 64'h8000_0000);
        wb_write(12'h341, 64'h1237);
        check_csr("mepc_align", 12'h341, 64'h1234);

        // Read before the edge sees the old value
        WB_V = 1'b1; WB_ST_CSR = 1'b1; WB_IR = {12'h340, 20'h0}; WB_CSR_DATA = 64'hDEAD_BEEF_CAFE_F00D;
        check_csr("no_bypass", 12'h340, 64'h0);
        tick();
        WB_V = 1'b0; WB_ST_CSR = 1'b0;
        check_csr("mscratch_wr", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);

        // Interrupt pending
        wb_write(12'h304, 64'h80);
        wb_write(12'h300, 64'h8);
        TIMER = 1'b1;
        #1;
        check("int_pend_on", {63'd0, CSR_INT_PENDING}, 64'd1);
        EXTERNAL = 1'b1; TIMER = 1'b0;
        #1;
        check("int_pend_ext_masked", {63'd0, CSR_INT_PENDING}, 64'd0);
        EXTERNAL = 1'b0;

        // Vectored interrupt trap with a concurrent mscratch write
        wb_write(12'h305, 64'h8000_0001);
        wb_write(12'h300, 64'h8);
        wb_write(12'hB02, 64'd100);
        check_csr("minstret_wr", 12'hB02, 64'd100);
        WB_ST_CSR = 1'b1; WB_IR = {12'h340, 20'h0}; WB_CSR_DATA = 64'h1111;
        wb_trap(64'h8000_0000_0000_0007, 64'h1006);
        WB_ST_CSR = 1'b0;
        check("save_state", {62'd0, dbg_state}, 64'd1);
        check("save_stall", {63'd0, CSR_STALL}, 64'd1);
        check("save_pcmux", {63'd0, CSR_PC_MUX}, 64'd0);
        check_csr("trap_mepc", 12'h341, 64'h1004);
        check_csr("trap_mcause", 12'h342, 64'h8000_0000_0000_0007);
        check_csr("trap_mstatus", 12'h300, 64'h1880);
        check_csr("trap_mscratch", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
        check_csr("trap_minstret", 12'hB02, 64'd100);
        tick();
        check("redir_pcmux", {63'd0, CSR_PC_MUX}, 64'd1);
        check("redir_stall", {63'd0, CSR_STALL}, 64'd1);
        check("redir_pc_vec", CSR_TRAP_PC, 64'h8000_001C);
        tick();
        check("idle_stall", {63'd0, CSR_STALL}, 64'd0);
        check("idle_pcmux", {63'd0, CSR_PC_MUX}, 64'd0);
        check("idle_pc_held", CSR_TRAP_PC, 64'h8000_001C);

        // Synchronous exception goes to BASE even in vectored mode
        wb_write(12'h300, 64'h8);
        wb_trap(64'hB, 64'h2000);
        stall_cnt = 0; pcmux_cnt = 0; redirect_pc = '0;
        for (int i = 0; i < 8; i++) begin
            if (CSR_STALL) stall_cnt++;
            if (CSR_PC_MUX) begin
                pcmux_cnt++;
                redirect_pc = CSR_TRAP_PC;
            end
            tick();
        end
        check("ecall_stall_cycles", 64'(stall_cnt), 64'd2);
        check("ecall_pcmux_cycles", 64'(pcmux_cnt), 64'd1);
        check("ecall_pc", redirect_pc, 64'h8000_0000);

        // MRET back to mepc
        check_csr("pre_mret_mstatus", 12'h300, 64'h1880);
        WB_MRET = 1'b1; WB_V = 1'b1; WB_ST_CSR = 1'b1; WB_IR = {12'h340, 20'h0}; WB_CSR_DATA = 64'h2222;
        tick();
        WB_MRET = 1'b0; WB_V = 1'b0; WB_ST_CSR = 1'b0;
        check("mret_pcmux", {63'd0, CSR_PC_MUX}, 64'd1);
        check("mret_pc", CSR_TRAP_PC, 64'h2000);
        check_csr("mret_mstatus", 12'h300, 64'h1888);
        check_csr("mret_drops_write", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        check("mret_done_stall", {63'd0, CSR_STALL}, 64'd0);

        // mcycle wrap
        wb_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        check_csr("mcycle_wr", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check_csr("mcycle_wrap", 12'hB00, 64'd0);
        tick();
        check_csr("mcycle_inc", 12'hB00, 64'd1);

        // Reset during SAVE aborts the sequence
        wb_trap(64'h8000_0000_0000_000B, 64'h3000);
        check("pre_abort_state", {62'd0, dbg_state}, 64'd1);
        RESET = 1'b0;
        #1;
        check("abort_stall_async", {63'd0, CSR_STALL}, 64'd0);
        tick();
        check_csr("abort_mcycle", 12'hB00, 64'd0);
        RESET = 1'b1;
        pcmux_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (CSR_PC_MUX) pcmux_cnt++;
        end
        check("abort_no_redirect", 64'(pcmux_cnt), 64'd0);
        check("abort_trap_pc", CSR_TRAP_PC, 64'd0);
        check_csr("abort_mstatus", 12'h300, 64'h1800);
        check_csr("abort_mie", 12'h304, 64'd0);
        check_csr("abort_mtvec", 12'h305, 64'd0);
        check_csr("abort_mscratch", 12'h340, 64'd0);
        check_csr("abort_mepc", 12'h341, 64'd0);
        check_csr("abort_mcause", 12'h342, 64'd0);
        check_csr("abort_minstret", 12'hB02, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
